// File: rtl/stim_sweep_ctrl.sv
// Exhaustive stimulus sweeper: drives every N_IN-bit pattern into a DUT, waits SETTLE_CYC
// extra cycles, samples the response and offers (pattern, response) on a valid/ready port.
// Optional build macro SWEEP_MISR_EN adds a running CRC-16 (x^16+x^12+x^5+1) signature output.
`timescale 1ns/1ps

module stim_sweep_ctrl #(
  parameter int N_IN       = 5,
  parameter int N_OUT      = 1,
  parameter int SETTLE_CYC = 1
`ifdef SWEEP_MISR_EN
  , parameter int SIG_W    = 16
`endif
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [N_IN-1:0]   cap_pattern,
  output logic [N_OUT-1:0]  cap_response,
  output logic              busy,
  output logic              done,
`ifdef SWEEP_MISR_EN
  output logic [SIG_W-1:0]  signature,
`endif
  output logic [N_IN:0]     pattern_count
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_PUSH, S_DONE} state_t;

  localparam int              CNT_W    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [N_IN-1:0]  LAST_PAT = '1;

  state_t            r_state,         w_state_nxt;
  logic [N_IN-1:0]   r_pattern,       w_pattern_nxt;
  logic [CNT_W-1:0]  r_cnt,           w_cnt_nxt;
  logic              r_cap_valid,     w_cap_valid_nxt;
  logic [N_IN-1:0]   r_cap_pattern,   w_cap_pattern_nxt;
  logic [N_OUT-1:0]  r_cap_response,  w_cap_response_nxt;
  logic [N_IN:0]     r_pattern_count, w_pattern_count_nxt;
  logic              w_handshake;

`ifdef SWEEP_MISR_EN
  localparam logic [SIG_W-1:0] POLY = SIG_W'(16'h1021);

  logic [SIG_W-1:0] r_sig, w_sig_nxt;

  function automatic logic [SIG_W-1:0] galois_step(input logic [SIG_W-1:0] s);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0);
  endfunction
`endif

  assign w_handshake = r_cap_valid & cap_ready;

  always_comb begin
    // NOTE: every next-state value gets its hold default first, so no path can infer a latch.
    w_state_nxt         = r_state;
    w_pattern_nxt       = r_pattern;
    w_cnt_nxt           = r_cnt;
    w_cap_valid_nxt     = r_cap_valid;
    w_cap_pattern_nxt   = r_cap_pattern;
    w_cap_response_nxt  = r_cap_response;
    w_pattern_count_nxt = r_pattern_count;
`ifdef SWEEP_MISR_EN
    w_sig_nxt           = r_sig;
`endif

    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_pattern_nxt   = '0;
      w_cap_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt         = S_SETTLE;
            w_pattern_nxt       = '0;
            w_cnt_nxt           = CNT_LOAD;
            w_pattern_count_nxt = '0;
`ifdef SWEEP_MISR_EN
            w_sig_nxt           = '1;
`endif
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_cap_response_nxt = dut_out;
            w_cap_pattern_nxt  = r_pattern;
            w_cap_valid_nxt    = 1'b1;
            w_state_nxt        = S_PUSH;
          end
        end
        S_PUSH: begin
          if (w_handshake) begin
            w_cap_valid_nxt     = 1'b0;
            w_pattern_count_nxt = r_pattern_count + (N_IN+1)'(1);
`ifdef SWEEP_MISR_EN
            w_sig_nxt = galois_step(r_sig) ^ SIG_W'({r_cap_pattern, r_cap_response});
`endif
            // Terminal pattern parks in DONE instead of wrapping back to zero.
            if (r_pattern == LAST_PAT) begin
              w_state_nxt = S_DONE;
            end else begin
              w_pattern_nxt = r_pattern + N_IN'(1);
              w_cnt_nxt     = CNT_LOAD;
              w_state_nxt   = S_SETTLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_pattern       <= '0;
      r_cnt           <= '0;
      r_cap_valid     <= 1'b0;
      r_cap_pattern   <= '0;
      r_cap_response  <= '0;
      r_pattern_count <= '0;
`ifdef SWEEP_MISR_EN
      r_sig           <= '1;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      r_state         <= w_state_nxt;
      r_pattern       <= w_pattern_nxt;
      r_cnt           <= w_cnt_nxt;
      r_cap_valid     <= w_cap_valid_nxt;
      r_cap_pattern   <= w_cap_pattern_nxt;
      r_cap_response  <= w_cap_response_nxt;
      r_pattern_count <= w_pattern_count_nxt;
`ifdef SWEEP_MISR_EN
      r_sig           <= w_sig_nxt;
`endif
    end
  end

  assign dut_in        = r_pattern;
  assign cap_valid     = r_cap_valid;
  assign cap_pattern   = r_cap_pattern;
  assign cap_response  = r_cap_response;
  assign pattern_count = r_pattern_count;
  assign busy          = (r_state == S_SETTLE) || (r_state == S_PUSH);
  assign done          = (r_state == S_DONE);
`ifdef SWEEP_MISR_EN
  assign signature     = r_sig;
`endif

endmodule

// File: doc/stim_sweep_ctrl.md
Name: stim_sweep_ctrl

Overview:
Synthesizable sequencer that exhaustively sweeps an N_IN-bit input vector into a device-under-test, waits a programmable settle time per vector, samples the DUT response and hands each (pattern, response) pair out over a valid/ready capture port. It replaces the hand-unrolled stimulus loop of the per-benchmark trojan-detection benches with one reusable controller that sits between the DUT and the result logger.

Parameters:
N_IN, 5, width of DUT stimulus vector; sweep covers 0 .. 2^N_IN-1
N_OUT, 1, width of DUT response
SETTLE_CYC, 1, extra wait cycles after applying a pattern before sampling (0 allowed)
SIG_W, 16, signature width (used only with SWEEP_MISR_EN)

Ports:
CK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin sweep; sampled in IDLE or DONE only
abort  in  1  terminate sweep; priority over start
dut_in  out  N_IN  stimulus to DUT; equals current pattern register
dut_out  in  N_OUT  DUT response
cap_valid  out  1  capture pair valid
cap_ready  in  1  logger accepts pair
cap_pattern  out  N_IN  pattern for the captured pair
cap_response  out  N_OUT  sampled dut_out
busy  out  1  high in SETTLE or PUSH
done  out  1  high in DONE
pattern_count  out  N_IN+1  number of accepted handshakes this sweep

Behaviour:
- Reset (reset=0, async): state=IDLE; dut_in=0, cap_valid=0, cap_pattern=0, cap_response=0, busy=0, done=0, pattern_count=0, settle counter=0.
- States: IDLE, SETTLE, PUSH, DONE.
- IDLE/DONE + start=1 (abort=0): pattern=0, settle cnt=SETTLE_CYC, pattern_count=0, done=0 -> SETTLE.
- SETTLE: cnt!=0 -> cnt-1. cnt==0 -> latch cap_response=dut_out, cap_pattern=pattern, cap_valid=1 -> PUSH. A pattern is therefore held on dut_in for SETTLE_CYC+1 cycles before sampling.
- PUSH: cap_valid, cap_pattern and cap_response are stable until cap_valid&cap_ready. On handshake: cap_valid=0, pattern_count+1. If pattern==2^N_IN-1 -> DONE (pattern unchanged). Otherwise pattern+1, cnt=SETTLE_CYC -> SETTLE.
- Throughput with cap_ready tied high: SETTLE_CYC+2 cycles per pattern. A full sweep is 2^N_IN*(SETTLE_CYC+2) cycles from start to DONE.
- DONE: done=1, busy=0, dut_in holds the last pattern. Stays in DONE until start or abort.
- abort=1 in any state: next edge -> IDLE. cap_valid=0, dut_in=0, pattern_count retained. abort and start together -> abort wins.
- start while busy: ignored.
- Pattern increment has no wrap: the terminal pattern goes to DONE, never back to 0. pattern_count reaches 2^N_IN exactly, hence N_IN+1 bits.
- Reset asserted mid-sweep: immediate return to reset values. No partial handshake survives.

Optional Feature:
SWEEP_MISR_EN: adds output port signature[SIG_W-1:0].
- Set to all-ones on the start transition.
- On each capture handshake: signature = galois_step(signature) XOR zero-extend({cap_pattern,cap_response}), with polynomial x^16+x^12+x^5+1.
- Holds its value in DONE. Reset value is all-ones.
- Without the macro the port and register are absent; behaviour is otherwise identical.

Test Plan:
- N_IN=5, SETTLE_CYC=1, cap_ready=1, dut_out=^dut_in. Pulse start. Required: 32 handshakes with cap_pattern 0..31 in order, cap_response = parity of the pattern, done rises 96 cycles after start, pattern_count=32.
- Backpressure: cap_ready low for 5 cycles at pattern 7. Required: cap_valid, cap_pattern=7 and cap_response stable throughout; no pattern skipped; dut_in stays 7 until the handshake.
- Abort at pattern 12 in SETTLE. Required: next cycle IDLE, busy=0, cap_valid=0, dut_in=0, pattern_count=12. A later start restarts at pattern 0.
- Drive start and abort together in IDLE, then start while busy. Required: the first stays in IDLE; the second is ignored and the sweep is unaffected.
- Async reset asserted mid-PUSH, between clock edges. Required: all outputs at reset values immediately, state IDLE after release.
- SWEEP_MISR_EN, SETTLE_CYC=0, dut_out=dut_in[0]. Required: done after 64 cycles; signature matches the bench reference model; a second sweep reproduces the identical signature.
